// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - requester and controller signal bundle for the SDRAM port arbiter
interface sdram_port_arbiter_if #(
  parameter int NUM_PORTS         = 4,
  parameter int PORT_ADDR_WIDTH   = 25,
  parameter int DATA_WIDTH        = 16,
  parameter int DQM_WIDTH         = 2,
  parameter int PORT_OUTPUT_WIDTH = 16
);
  logic [NUM_PORTS-1:0]                 req_wr;
  logic [NUM_PORTS-1:0]                 req_rd;
  logic [NUM_PORTS*PORT_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0]      req_data;
  logic [NUM_PORTS*DQM_WIDTH-1:0]       req_byte_en;
  logic [NUM_PORTS-1:0]                 req_ack;
  logic [NUM_PORTS-1:0]                 req_ready;
  logic [PORT_OUTPUT_WIDTH-1:0]         req_q;

  logic [PORT_ADDR_WIDTH-1:0]           ctl_addr;
  logic [DATA_WIDTH-1:0]                ctl_data;
  logic [DQM_WIDTH-1:0]                 ctl_byte_en;
  logic                                 ctl_wr;
  logic                                 ctl_rd;
  logic [PORT_OUTPUT_WIDTH-1:0]         ctl_q;
  logic                                 ctl_available;
  logic                                 ctl_ready;

  modport slave (
    input  req_wr, req_rd, req_addr, req_data, req_byte_en,
    input  ctl_q, ctl_available, ctl_ready,
    output req_ack, req_ready, req_q,
    output ctl_addr, ctl_data, ctl_byte_en, ctl_wr, ctl_rd
  );

  modport master (
    output req_wr, req_rd, req_addr, req_data, req_byte_en,
    output ctl_q, ctl_available, ctl_ready,
    input  req_ack, req_ready, req_q,
    input  ctl_addr, ctl_data, ctl_byte_en, ctl_wr, ctl_rd
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin arbiter sharing one SDRAM controller port among requesters
module sdram_port_arbiter #(
  parameter int NUM_PORTS         = 4,
  parameter int PORT_ADDR_WIDTH   = 25,
  parameter int DATA_WIDTH        = 16,
  parameter int DQM_WIDTH         = 2,
  parameter int PORT_OUTPUT_WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  sdram_port_arbiter_if.slave bus
);
  localparam int             IDX_W = $clog2(NUM_PORTS);
  localparam logic [IDX_W:0] NP    = (IDX_W+1)'(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, HOLD} state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             owner_q, owner_d, last_q, last_d, win;
  logic [PORT_ADDR_WIDTH-1:0]   addr_q, addr_d, sel_addr;
  logic [DATA_WIDTH-1:0]        data_q, data_d, sel_data;
  logic [DQM_WIDTH-1:0]         ben_q, ben_d, sel_ben;
  logic [PORT_OUTPUT_WIDTH-1:0] rq_q, rq_d;
  logic                         op_wr_q, op_wr_d, rdy_q, rdy_d;
  logic                         sel_wr, found;
  logic [NUM_PORTS-1:0]         pending;
  logic [IDX_W:0]               probe;

  assign pending = bus.req_wr | bus.req_rd;

  // First pending port strictly after the last grant, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    probe = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      probe = {1'b0, last_q} + (IDX_W+1)'(k);
      if (probe >= NP) probe = probe - NP;
      if (!found && pending[probe[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = probe[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_ben  = '0;
    sel_wr   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (IDX_W'(i) == win) begin
        sel_addr = bus.req_addr[i*PORT_ADDR_WIDTH +: PORT_ADDR_WIDTH];
        sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ben  = bus.req_byte_en[i*DQM_WIDTH +: DQM_WIDTH];
        sel_wr   = bus.req_wr[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_PORTS-1);
      addr_q  <= '0;
      data_q  <= '0;
      ben_q   <= '0;
      op_wr_q <= 1'b0;
      rq_q    <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ben_q   <= ben_d;
      op_wr_q <= op_wr_d;
      rq_q    <= rq_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ben_d   = ben_q;
    op_wr_d = op_wr_q;
    rq_d    = rq_q;
    rdy_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && bus.ctl_available) begin
          state_d = ISSUE;
          owner_d = win;
          last_d  = win;
          addr_d  = sel_addr;
          data_d  = sel_data;
          ben_d   = sel_ben;
          op_wr_d = sel_wr;
        end
      end
      ISSUE:   state_d = op_wr_q ? HOLD : WAIT_RD;
      // HOLD absorbs the controller's one-cycle delay in dropping ctl_available.
      HOLD:    state_d = IDLE;
      WAIT_RD: begin
        if (bus.ctl_ready) begin
          rq_d    = bus.ctl_q;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ack   = '0;
    bus.req_ready = '0;
    bus.ctl_wr    = 1'b0;
    bus.ctl_rd    = 1'b0;
    if (state_q == ISSUE) begin
      bus.req_ack[owner_q] = 1'b1;
      bus.ctl_wr           = op_wr_q;
      bus.ctl_rd           = !op_wr_q;
    end
    if (rdy_q) bus.req_ready[owner_q] = 1'b1;
  end

  assign bus.ctl_addr    = addr_q;
  assign bus.ctl_data    = data_q;
  assign bus.ctl_byte_en = ben_q;
  assign bus.req_q       = rq_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
  localparam int NP = 4;
  localparam int IW = 2;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int QW = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.NUM_PORTS(NP), .PORT_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                          .DQM_WIDTH(BW), .PORT_OUTPUT_WIDTH(QW)) bus ();

  sdram_port_arbiter #(.NUM_PORTS(NP), .PORT_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .DQM_WIDTH(BW), .PORT_OUTPUT_WIDTH(QW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input int last, input logic [NP-1:0] pend);
    int idx;
    pick = -1;
    for (int k = NP; k >= 1; k--) begin
      idx = (last + k) % NP;
      if (pend[idx[IW-1:0]]) pick = idx;
    end
  endfunction

  // Transaction-level model: cycle numbers of when the port frees up.
  int             m_last, m_idle_at, m_d, m_rd_from, m_win;
  logic           m_rd_wait;
  logic [IW-1:0]  m_sel, m_rd_owner;
  logic [NP-1:0]  exp_ack, exp_ready;
  logic           exp_wr, exp_rd;
  logic [AW-1:0]  exp_addr;
  logic [DW-1:0]  exp_data;
  logic [BW-1:0]  exp_ben;
  logic [QW-1:0]  exp_q;

  assign m_win = pick(m_last, bus.req_wr | bus.req_rd);
  assign m_sel = m_win[IW-1:0];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last <= NP-1; m_idle_at <= 0; m_d <= 0; m_rd_from <= 0; m_rd_wait <= 1'b0;
      m_rd_owner <= '0; exp_ack <= '0; exp_ready <= '0; exp_wr <= 1'b0; exp_rd <= 1'b0;
      exp_addr <= '0; exp_data <= '0; exp_ben <= '0; exp_q <= '0;
    end else begin
      m_d       <= m_d + 1;
      exp_ack   <= '0;
      exp_ready <= '0;
      exp_wr    <= 1'b0;
      exp_rd    <= 1'b0;
      if (!m_rd_wait && m_d >= m_idle_at && m_win >= 0 && bus.ctl_available) begin
        m_last   <= m_win;
        exp_ack  <= NP'(1) << m_sel;
        exp_addr <= bus.req_addr[m_sel*AW +: AW];
        exp_data <= bus.req_data[m_sel*DW +: DW];
        exp_ben  <= bus.req_byte_en[m_sel*BW +: BW];
        if (bus.req_wr[m_sel]) begin
          exp_wr    <= 1'b1;
          m_idle_at <= m_d + 3;
        end else begin
          exp_rd     <= 1'b1;
          m_rd_wait  <= 1'b1;
          m_rd_from  <= m_d + 2;
          m_rd_owner <= m_sel;
        end
      end else if (m_rd_wait && m_d >= m_rd_from && bus.ctl_ready) begin
        exp_ready <= NP'(1) << m_rd_owner;
        exp_q     <= bus.ctl_q;
        m_rd_wait <= 1'b0;
        m_idle_at <= m_d + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_req_ack",   64'(bus.req_ack),     64'(exp_ack));
      chk("cmp_req_ready", 64'(bus.req_ready),   64'(exp_ready));
      chk("cmp_req_q",     64'(bus.req_q),       64'(exp_q));
      chk("cmp_ctl_wr",    64'(bus.ctl_wr),      64'(exp_wr));
      chk("cmp_ctl_rd",    64'(bus.ctl_rd),      64'(exp_rd));
      chk("cmp_ctl_addr",  64'(bus.ctl_addr),    64'(exp_addr));
      chk("cmp_ctl_data",  64'(bus.ctl_data),    64'(exp_data));
      chk("cmp_ctl_ben",   64'(bus.ctl_byte_en), 64'(exp_ben));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic wait_ack(output int who);
    bit got;
    who = -1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (bus.req_ack != '0) begin
        got = 1'b1;
        for (int p = 0; p < NP; p++) if (bus.req_ack[p]) who = p;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: actual=no req_ack required=req_ack within 30 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int who, prev;
    bus.req_wr = '0; bus.req_rd = '0; bus.req_addr = '0; bus.req_data = '0;
    bus.req_byte_en = '0; bus.ctl_q = '0; bus.ctl_available = 1'b1; bus.ctl_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_ack",  64'(bus.req_ack),  64'(0));
    chk("reset_q",    64'(bus.req_q),    64'(0));
    chk("reset_addr", 64'(bus.ctl_addr), 64'(0));

    // single read, port 1
    bus.req_addr[1*AW +: AW] = 25'h0001234;
    bus.req_rd = 4'b0010;
    wait_ack(who);
    chk("t1_owner", 64'(who),          64'(1));
    chk("t1_ack",   64'(bus.req_ack),  64'(4'b0010));
    chk("t1_rd",    64'(bus.ctl_rd),   64'(1));
    chk("t1_addr",  64'(bus.ctl_addr), 64'(25'h0001234));
    bus.req_rd = '0;
    tick();
    chk("t1_rd_once", 64'(bus.ctl_rd), 64'(0));
    tick(); tick(); tick();
    bus.ctl_q = 16'hBEEF;
    bus.ctl_ready = 1'b1;
    tick();
    bus.ctl_ready = 1'b0;
    chk("t1_ready", 64'(bus.req_ready), 64'(4'b0010));
    chk("t1_q",     64'(bus.req_q),     64'(16'hBEEF));

    // single write, port 3
    bus.req_data[3*DW +: DW] = 16'h5A5A;
    bus.req_byte_en[3*BW +: BW] = 2'b01;
    bus.req_wr = 4'b1000;
    wait_ack(who);
    chk("t2_ack",  64'(bus.req_ack),     64'(4'b1000));
    chk("t2_wr",   64'(bus.ctl_wr),      64'(1));
    chk("t2_data", 64'(bus.ctl_data),    64'(16'h5A5A));
    chk("t2_ben",  64'(bus.ctl_byte_en), 64'(2'b01));
    bus.req_wr = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_no_ready", 64'(bus.req_ready), 64'(0));
    end

    // contention: all ports write continuously
    bus.req_wr = 4'b1111;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_ack(who);
      chk("t3_order", 64'(who), 64'(g % NP));
      if (g > 0) chk("t3_gap", 64'(cyc - prev), 64'(3));
      prev = cyc;
    end
    bus.req_wr = '0;
    tick(); tick(); tick();

    // fairness: last grant port 2, then ports 0 and 3 pending
    bus.req_wr = 4'b0100;
    wait_ack(who);
    chk("t4_setup", 64'(who), 64'(2));
    bus.req_wr = '0;
    tick(); tick(); tick();
    bus.req_wr = 4'b1001;
    wait_ack(who);
    chk("t4_first", 64'(who), 64'(3));
    bus.req_wr = 4'b0001;
    wait_ack(who);
    chk("t4_second", 64'(who), 64'(0));
    bus.req_wr = '0;
    tick(); tick(); tick();

    // backpressure, then wr+rd on the same port
    bus.req_addr[0 +: AW] = 25'h00ABCDE;
    bus.req_data[0 +: DW] = 16'h1357;
    bus.req_byte_en[0 +: BW] = 2'b11;
    bus.ctl_available = 1'b0;
    bus.req_wr = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_blocked_ack", 64'(bus.req_ack),               64'(0));
      chk("t5_blocked_str", 64'({bus.ctl_wr, bus.ctl_rd}),  64'(0));
    end
    bus.req_rd = 4'b0001;
    bus.ctl_available = 1'b1;
    wait_ack(who);
    chk("t5_first_wr", 64'(bus.ctl_wr), 64'(1));
    chk("t5_first_rd", 64'(bus.ctl_rd), 64'(0));
    bus.req_wr = '0;
    wait_ack(who);
    chk("t5_then_rd", 64'(bus.ctl_rd),  64'(1));
    chk("t5_rd_ack",  64'(bus.req_ack), 64'(4'b0001));
    bus.req_rd = '0;
    tick(); tick();

    // reset while waiting for read data
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_q",    64'(bus.req_q),       64'(0));
    chk("t6_rst_addr", 64'(bus.ctl_addr),    64'(0));
    chk("t6_rst_data", 64'(bus.ctl_data),    64'(0));
    chk("t6_rst_ben",  64'(bus.ctl_byte_en), 64'(0));
    chk("t6_rst_str",  64'({bus.ctl_wr, bus.ctl_rd, bus.req_ack, bus.req_ready}), 64'(0));
    tick(); tick();
    rst = 1'b0;
    tick();
    bus.ctl_q = 16'hDEAD;
    bus.ctl_ready = 1'b1;
    tick();
    bus.ctl_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_ready", 64'(bus.req_ready), 64'(0));
      tick();
    end
    bus.req_wr = 4'b0101;
    wait_ack(who);
    chk("t6_next_grant", 64'(who), 64'(0));
    bus.req_wr = '0;
    tick(); tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Round-robin arbiter that shares one SDRAM controller port (addr/data/byte_en/q/wr/rd/available/ready) among NUM_PORTS requesters. It sits between client blocks and the SDRAM port wrapper. It registers one command at a time toward the controller and routes read data and completion back to the owning requester. Only one transaction is outstanding at a time.

## Interface
Parameters:
- NUM_PORTS, 4, number of requesters (2..8)
- PORT_ADDR_WIDTH, 25, word address width
- DATA_WIDTH, 16, write data width
- DQM_WIDTH, 2, byte-enable width
- PORT_OUTPUT_WIDTH, 16, read data width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  single clock for all logic
  - reset  in  1  asynchronous, active-high reset
- Requester side:
  - req_wr  in  NUM_PORTS  per-requester write request; level, held until ack
  - req_rd  in  NUM_PORTS  per-requester read request; level, held until ack
  - req_addr  in  NUM_PORTS*PORT_ADDR_WIDTH  flattened; slice i belongs to requester i
  - req_data  in  NUM_PORTS*DATA_WIDTH  flattened write data
  - req_byte_en  in  NUM_PORTS*DQM_WIDTH  flattened byte enables
  - req_ack  out  NUM_PORTS  one-cycle pulse: command accepted
  - req_ready  out  NUM_PORTS  one-cycle pulse: read data valid on req_q
  - req_q  out  PORT_OUTPUT_WIDTH  read data, shared by all requesters
- Controller side:
  - ctl_addr  out  PORT_ADDR_WIDTH  registered command address
  - ctl_data  out  DATA_WIDTH  registered write data
  - ctl_byte_en  out  DQM_WIDTH  registered byte enables
  - ctl_wr  out  1  one-cycle write strobe
  - ctl_rd  out  1  one-cycle read strobe
  - ctl_q  in  PORT_OUTPUT_WIDTH  controller read data
  - ctl_available  in  1  controller can accept a command; deasserts the cycle after it accepts one
  - ctl_ready  in  1  one-cycle pulse: ctl_q valid for the issued read

## Operation
- States: IDLE, ISSUE, WAIT_RD, HOLD.
- IDLE:
  - Pending = req_wr | req_rd.
  - If any requester is pending and ctl_available=1, select the winner and latch owner index, addr, data, byte_en and op. Then go to ISSUE.
  - Otherwise stay in IDLE.
- Round robin:
  - Search begins at last_grant+1, modulo NUM_PORTS.
  - last_grant updates on each grant.
  - Reset value of last_grant is NUM_PORTS-1, so port 0 wins first.
- Op selection: if req_wr[i] and req_rd[i] are both high, the request is a write. The read stays pending and is served at a later grant.
- ISSUE (1 cycle):
  - Drive ctl_wr or ctl_rd = 1 with the latched fields, and pulse req_ack[owner].
  - A read goes to WAIT_RD; a write goes to HOLD.
- HOLD (1 cycle): covers the controller's available-deassert latency, then go to IDLE.
- WAIT_RD:
  - On ctl_ready, register ctl_q into req_q and pulse req_ready[owner] on the next cycle. Go to IDLE in that same transition.
  - ctl_ready is ignored in every other state.
- ctl_addr/ctl_data/ctl_byte_en hold their last values outside ISSUE. req_q holds the last read data.
- Requesters must drop the request in the cycle after req_ack. A request still high after that is treated as a new request.
- Reset (asynchronous, any state):
  - State goes to IDLE and all outputs go to 0. last_grant = NUM_PORTS-1.
  - An in-flight read is abandoned and no req_ready is issued for it.

## Timing
- Grant decision in IDLE at cycle t (pending and ctl_available=1). ctl_wr/ctl_rd and req_ack are high in cycle t+1 only.
- Write: earliest next grant decision is at t+3 (ISSUE t+1, HOLD t+2, IDLE t+3).
- Read: ctl_ready at cycle r gives req_ready and req_q valid at r+1. Earliest next grant decision is also at r+1.
- Maximum throughput is one write per 3 cycles. Reads are limited by the controller's ready latency.
- At most one of ctl_wr and ctl_rd is high in any cycle. req_ack and req_ready are one-hot or zero.
- ctl_available=0 in IDLE blocks all grants indefinitely, and the round-robin pointer is unchanged.

## Test plan
- Single read, port 1:
  - Stimulus: req_rd[1]=1, addr 0x0001234, ctl_available=1; controller returns ctl_ready with ctl_q=0xBEEF 4 cycles after ctl_rd.
  - Required: ctl_rd high for exactly 1 cycle with ctl_addr=0x0001234, req_ack=4'b0010. One cycle after ctl_ready: req_ready=4'b0010 and req_q=0xBEEF.
- Single write, port 3:
  - Stimulus: req_wr[3]=1, data 0x5A5A, byte_en 2'b01.
  - Required: ctl_wr for 1 cycle with ctl_data=0x5A5A, ctl_byte_en=2'b01; req_ack[3] in the same cycle; no req_ready.
- Contention:
  - Stimulus: all 4 ports request writes from reset and re-assert after each ack.
  - Required: grant order 0,1,2,3,0,… with ctl_wr strobes spaced exactly 3 cycles apart.
- Fairness:
  - Stimulus: last grant was port 2; ports 0 and 3 are pending.
  - Required: port 3 is granted next, then port 0.
- Backpressure and same-port wr+rd:
  - Stimulus: ctl_available=0 for 10 cycles with port 0 pending; then req_wr[0]=req_rd[0]=1.
  - Required: no strobes during the 10 cycles; the first command is a write.
- Reset mid-read:
  - Stimulus: assert reset while in WAIT_RD, then pulse ctl_ready after reset releases.
  - Required: all outputs are 0 immediately on reset; no req_ready after release; the next grant goes to port 0.
